// File: rtl/dcache_port_scheduler_if.sv
// Bundle of the load, store, D-cache and load-response signals around the
// D-cache port scheduler. The scheduler uses the slave view; its environment uses the master view.
interface dcache_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int CNT_W  = 4
);
    logic              flush;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_ready;

    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic [CNT_W-1:0]  sb_count;

    logic              dc_req_valid;
    logic              dc_req_write;
    logic [ADDR_W-1:0] dc_req_addr;
    logic [DATA_W-1:0] dc_req_data;
    logic              dc_busy;
    logic              dc_rd_valid;
    logic [DATA_W-1:0] dc_rd_data;

    logic              ld_resp_valid;
    logic [TAG_W-1:0]  ld_resp_tag;
    logic [DATA_W-1:0] ld_resp_data;

    modport slave (
        input  flush,
        input  ld_valid, ld_addr, ld_tag,
        output ld_ready,
        input  st_valid, st_addr, st_data,
        output st_ready, sb_count,
        output dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
        input  dc_busy, dc_rd_valid, dc_rd_data,
        output ld_resp_valid, ld_resp_tag, ld_resp_data
    );

    modport master (
        output flush,
        output ld_valid, ld_addr, ld_tag,
        input  ld_ready,
        output st_valid, st_addr, st_data,
        input  st_ready, sb_count,
        input  dc_req_valid, dc_req_write, dc_req_addr, dc_req_data,
        output dc_busy, dc_rd_valid, dc_rd_data,
        input  ld_resp_valid, ld_resp_tag, ld_resp_data
    );
endinterface

// File: rtl/dcache_port_scheduler.sv
// Arbitrates the single D-cache port between speculative loads and committed
// stores held in a FIFO store buffer; loads win unless starved stores, a full buffer or an address conflict force a store.
module dcache_port_scheduler #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TAG_W        = 4,
    parameter int SB_DEPTH     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    dcache_port_if.slave bus
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        LD_WAIT = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   kill_reg, kill_next;

    // Store buffer: pointers carry a wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [ADDR_W-1:0] sb_addr_mem [SB_DEPTH];
    logic [DATA_W-1:0] sb_data_mem [SB_DEPTH];
    logic [CNT_W-1:0]  sb_count;
    logic              sb_empty, sb_full, sb_push, sb_pop;
    logic [PTR_W-1:0]  wr_idx, rd_idx;

    logic [STV_W-1:0]  starve_reg, starve_next;

    logic              req_write_reg;
    logic [ADDR_W-1:0] req_addr_reg;
    logic [DATA_W-1:0] req_data_reg;
    logic [TAG_W-1:0]  req_tag_reg;

    logic              resp_valid_reg, resp_fire;
    logic [TAG_W-1:0]  resp_tag_reg;
    logic [DATA_W-1:0] resp_data_reg;

    logic [SB_DEPTH-1:0] entry_hit;
    logic              conflict, force_st, ld_grant, st_grant;

    assign wr_idx   = wr_ptr_reg[PTR_W-1:0];
    assign rd_idx   = rd_ptr_reg[PTR_W-1:0];
    assign sb_count = wr_ptr_reg - rd_ptr_reg;
    assign sb_empty = (wr_ptr_reg == rd_ptr_reg);
    assign sb_full  = (sb_count == CNT_W'(SB_DEPTH));
    assign sb_push  = bus.st_valid && !sb_full;
    assign sb_pop   = (state_reg == REQ) && !bus.dc_busy && req_write_reg;

    // An entry is live when its distance from the read pointer is below the count;
    // the head stays live while it is being written to the cache.
    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_conflict
            logic [PTR_W-1:0] offset;
            assign offset        = PTR_W'(gi) - rd_idx;
            assign entry_hit[gi] = ({1'b0, offset} < sb_count) &&
                                   (sb_addr_mem[gi][ADDR_W-1:2] == bus.ld_addr[ADDR_W-1:2]);
        end
    endgenerate

    assign conflict = |entry_hit;
    assign force_st = !sb_empty &&
                      (sb_full || (starve_reg == STV_W'(STARVE_LIMIT)) || conflict);
    assign ld_grant = (state_reg == IDLE) && !force_st && bus.ld_valid &&
                      !conflict && !bus.flush;
    assign st_grant = (state_reg == IDLE) && !ld_grant && !sb_empty;

    always_comb begin
        starve_next = starve_reg;
        if (st_grant) begin
            starve_next = '0;
        end else if (ld_grant && !sb_empty && (starve_reg != STV_W'(STARVE_LIMIT))) begin
            starve_next = starve_reg + STV_W'(1);
        end
    end

    always_comb begin
        state_next = state_reg;
        kill_next  = kill_reg;
        resp_fire  = 1'b0;
        case (state_reg)
            IDLE: begin
                kill_next = 1'b0;
                if (ld_grant || st_grant) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.flush && !req_write_reg) begin
                    kill_next = 1'b1;
                end
                if (!bus.dc_busy) begin
                    state_next = req_write_reg ? IDLE : LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (bus.flush) begin
                    kill_next = 1'b1;
                end
                if (bus.dc_rd_valid) begin
                    state_next = IDLE;
                    resp_fire  = !kill_reg && !bus.flush;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            kill_reg       <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            starve_reg     <= '0;
            req_write_reg  <= 1'b0;
            req_addr_reg   <= '0;
            req_data_reg   <= '0;
            req_tag_reg    <= '0;
            resp_valid_reg <= 1'b0;
            resp_tag_reg   <= '0;
            resp_data_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            kill_reg       <= kill_next;
            starve_reg     <= starve_next;
            resp_valid_reg <= resp_fire;
            if (sb_push) begin
                wr_ptr_reg <= wr_ptr_reg + CNT_W'(1);
            end
            if (sb_pop) begin
                rd_ptr_reg <= rd_ptr_reg + CNT_W'(1);
            end
            if (ld_grant) begin
                req_write_reg <= 1'b0;
                req_addr_reg  <= bus.ld_addr;
                req_data_reg  <= '0;
                req_tag_reg   <= bus.ld_tag;
            end else if (st_grant) begin
                req_write_reg <= 1'b1;
                req_addr_reg  <= sb_addr_mem[rd_idx];
                req_data_reg  <= sb_data_mem[rd_idx];
            end
            if (resp_fire) begin
                resp_tag_reg  <= req_tag_reg;
                resp_data_reg <= bus.dc_rd_data;
            end
        end
    end

    // Buffer storage needs no reset: liveness is defined purely by the pointers.
    always_ff @(posedge clk) begin
        if (sb_push) begin
            sb_addr_mem[wr_idx] <= bus.st_addr;
            sb_data_mem[wr_idx] <= bus.st_data;
        end
    end

    assign bus.ld_ready      = ld_grant;
    assign bus.st_ready      = !sb_full;
    assign bus.sb_count      = sb_count;
    assign bus.dc_req_valid  = (state_reg == REQ);
    assign bus.dc_req_write  = req_write_reg;
    assign bus.dc_req_addr   = req_addr_reg;
    assign bus.dc_req_data   = req_data_reg;
    assign bus.ld_resp_valid = resp_valid_reg;
    assign bus.ld_resp_tag   = resp_tag_reg;
    assign bus.ld_resp_data  = resp_data_reg;

endmodule
